// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MADD/MADDU accumulate ops are enabled by defining ALU_MULDIV_MADD_EN.
module alu_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef ALU_MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t               r_state, w_nxt;
  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;      // product, or {remainder, dividend/quotient}
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg, r_rneg, r_dz;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_div_zero;

  logic                 w_in_mul, w_in_div, w_accept, w_mthi, w_mtlo;
  logic                 w_mul, w_sgn, w_madd;
  logic                 w_sa, w_sb;
  logic [WIDTH-1:0]     w_amag, w_bmag;
  logic [WIDTH:0]       w_sum, w_trial;
  logic [2*WIDTH-1:0]   w_prod, w_prod_f;
  logic [WIDTH-1:0]     w_quo, w_rem;

  // Input-side decode (only meaningful in IDLE)
  always_comb begin
    w_in_mul = (op == OP_MULT) || (op == OP_MULTU);
    w_in_div = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef ALU_MULDIV_MADD_EN
    w_in_mul = w_in_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
    w_accept = (r_state == S_IDLE) && start && (w_in_mul || w_in_div);
    w_mthi   = (r_state == S_IDLE) && start && (op == OP_MTHI);
    w_mtlo   = (r_state == S_IDLE) && start && (op == OP_MTLO);
  end

  // Latched-op decode
  always_comb begin
    w_mul  = (r_op == OP_MULT) || (r_op == OP_MULTU);
    w_sgn  = (r_op == OP_MULT) || (r_op == OP_DIV);
    w_madd = 1'b0;
`ifdef ALU_MULDIV_MADD_EN
    w_mul  = w_mul || (r_op == OP_MADD) || (r_op == OP_MADDU);
    w_sgn  = w_sgn || (r_op == OP_MADD);
    w_madd = (r_op == OP_MADD) || (r_op == OP_MADDU);
`endif
  end

  // Magnitudes; the most negative value negates to itself, which read unsigned is 2^(WIDTH-1)
  always_comb begin
    w_sa   = w_sgn & r_a[WIDTH-1];
    w_sb   = w_sgn & r_b[WIDTH-1];
    w_amag = w_sa ? -r_a : r_a;
    w_bmag = w_sb ? -r_b : r_b;
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  end

  // Sign fix-up and optional accumulate
  always_comb begin
    w_prod   = r_neg ? -r_acc : r_acc;
    w_prod_f = w_prod;
    if (w_madd) w_prod_f = w_prod + {r_hi, r_lo};
    w_quo    = r_neg  ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    w_rem    = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nxt = S_PREP;
      S_PREP:  w_nxt = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(1)) w_nxt = S_FIX;
      S_FIX:   w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_opnd <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= op;
          r_a  <= a;
          r_b  <= b;
        end
        S_PREP: begin
          r_opnd <= w_mul ? w_amag : w_bmag;
          r_acc  <= {{WIDTH{1'b0}}, (w_mul ? w_bmag : w_amag)};
          r_neg  <= w_sa ^ w_sb;
          r_rneg <= w_sa;
          r_dz   <= !w_mul && (r_b == '0);
          r_cnt  <= CNT_W'(WIDTH);
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_mul)
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          else if (!w_trial[WIDTH])
            r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          else
            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // HI/LO change only on MTHI/MTLO in IDLE or at the FIX->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_accept) r_div_zero <= 1'b0;
      if (w_mthi)   r_hi <= a;
      if (w_mtlo)   r_lo <= a;
      if (r_state == S_FIX) begin
        if (w_mul) begin
          {r_hi, r_lo} <= w_prod_f;
        end else if (r_dz) begin
          r_hi       <= r_a;
          r_lo       <= '1;
          r_div_zero <= 1'b1;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32; define ALU_MULDIV_MADD_EN to cover MADDU.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Drive one start; returns just after the accepting edge (cycle 1)
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bounded wait: lat = first cycle done is seen (-1 if never), bc = busy cycles
  task automatic wait_done(output int lat, output int bc);
    lat = -1; bc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done && lat < 0) lat = k;
      if (!busy && lat >= 0) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (hi !== 32'h0)      begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_chk++; if (lo !== 32'h0)      begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_chk++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bc;
    start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    n_chk++; if (lat != 35) begin n_fail++; $display("FAIL multu_done_cycle: got %0d want 35", lat); end
    n_chk++; if (bc != 35)  begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 35", bc); end
    n_chk++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    n_chk++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_mult_mtlo;
    int lat, bc;
    start_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, bc);
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_chk++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    start_op(3'd5, 32'h0000_1234, 32'h0);
    n_chk++; if (lo !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_lo: got %h want 00001234", lo); end
    n_chk++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtlo_hi: got %h want ffffffff", hi); end
  endtask

  task automatic test_div;
    int lat, bc;
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bc);
    n_chk++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    n_chk++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    n_chk++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_min_lo: got %h want 80000000", lo); end
    n_chk++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL div_min_hi: got %h want 0", hi); end
    n_chk++; if (div_zero !== 1'b0)    begin n_fail++; $display("FAIL div_min_dz: got %b want 0", div_zero); end
  endtask

  task automatic test_divzero;
    int lat, bc;
    start_op(3'd3, 32'd7, 32'd0);
    wait_done(lat, bc);
    n_chk++; if (lat != 35)            begin n_fail++; $display("FAIL dz_done_cycle: got %0d want 35", lat); end
    n_chk++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    n_chk++; if (hi !== 32'd7)         begin n_fail++; $display("FAIL dz_hi: got %h want 00000007", hi); end
    n_chk++; if (div_zero !== 1'b1)    begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    start_op(3'd1, 32'd2, 32'd3);
    n_chk++; if (div_zero !== 1'b0)    begin n_fail++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    wait_done(lat, bc);
    n_chk++; if (hi !== 32'd0)         begin n_fail++; $display("FAIL dz_next_hi: got %h want 0", hi); end
    n_chk++; if (lo !== 32'd6)         begin n_fail++; $display("FAIL dz_next_lo: got %h want 00000006", lo); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, dcnt;
    start_op(3'd1, 32'd5, 32'd5);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    n_chk++; if (lat != 31)         begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 31", lat); end
    n_chk++; if (hi !== 32'd0)      begin n_fail++; $display("FAIL ignore_hi: got %h want 0", hi); end
    n_chk++; if (lo !== 32'd25)     begin n_fail++; $display("FAIL ignore_lo: got %h want 00000019", lo); end
    n_chk++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL ignore_dz: got %b want 0", div_zero); end
    start_op(3'd1, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_chk++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
    n_chk++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0; bc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bc++;
    end
    n_chk++; if (dcnt != 0) begin n_fail++; $display("FAIL rst_mid_done_pulses: got %0d want 0", dcnt); end
    n_chk++; if (bc != 0)   begin n_fail++; $display("FAIL rst_mid_busy_after: got %0d want 0", bc); end
  endtask

  task automatic test_madd;
    int lat, bc;
`ifdef ALU_MULDIV_MADD_EN
    start_op(3'd4, 32'h0, 32'h0);
    start_op(3'd5, 32'hFFFF_FFFF, 32'h0);
    start_op(3'd7, 32'd1, 32'd1);
    wait_done(lat, bc);
    n_chk++; if (lat != 35)    begin n_fail++; $display("FAIL maddu_done_cycle: got %0d want 35", lat); end
    n_chk++; if (hi !== 32'd1) begin n_fail++; $display("FAIL maddu_hi: got %h want 00000001", hi); end
    n_chk++; if (lo !== 32'd0) begin n_fail++; $display("FAIL maddu_lo: got %h want 0", lo); end
`else
    start_op(3'd4, 32'h55, 32'h0);
    start_op(3'd5, 32'hAA, 32'h0);
    start_op(3'd7, 32'd1, 32'd1);
    bc = 0; lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) lat++;
    end
    n_chk++; if (bc != 0)       begin n_fail++; $display("FAIL op7_busy: got %0d want 0", bc); end
    n_chk++; if (lat != 0)      begin n_fail++; $display("FAIL op7_done: got %0d want 0", lat); end
    n_chk++; if (hi !== 32'h55) begin n_fail++; $display("FAIL op7_hi: got %h want 00000055", hi); end
    n_chk++; if (lo !== 32'hAA) begin n_fail++; $display("FAIL op7_lo: got %h want 000000aa", lo); end
`endif
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult_mtlo;
    test_div;
    test_divzero;
    test_back_to_back;
    test_madd;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the multi-cycle MIPS datapath. Sits beside the combinational ALU and owns the HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Uses a start/busy/done handshake so the control FSM can stall until results are ready.
- Generalises the fixed 32-bit ALU to WIDTH bits and adds sequential multi-cycle operations.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal values ≥ 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- op  input  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
- a  input  WIDTH  operand A (multiplicand/dividend, or MTHI/MTLO source)
- b  input  WIDTH  operand B (multiplier/divisor)
- busy  output  1  high while a multi-cycle operation is in progress
- done  output  1  one-cycle pulse when hi/lo are updated by a multi-cycle op
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)
- div_zero  output  1  last DIV/DIVU had b == 0; held until the next accepted start

Behaviour:
- Reset:
  - Asserting rst_n low clears everything immediately, regardless of clock.
  - Values: state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
  - A reset mid-operation abandons the operation; no partial result reaches hi/lo.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - start=1 with op 0–3 (or 6–7, see Optional Feature): latch a, b and op; clear div_zero; go to PREP; busy=1 from the next cycle.
  - start=1 with op 4/5: hi<=a or lo<=a at that edge; stay in IDLE; busy and done stay 0.
  - Illegal op: ignored.
- PREP, 1 cycle:
  - Signed ops: take magnitudes of a and b. The most negative value maps to its unsigned magnitude 2^(WIDTH-1).
  - Record result sign and remainder sign (= dividend sign).
  - Load counter=WIDTH. Go to CALC.
- CALC, WIDTH cycles:
  - Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; at 1 go to FIX.
- FIX, 1 cycle:
  - Negate the product, or quotient/remainder, as required by the recorded signs. All arithmetic is modulo 2^WIDTH per half.
- DONE, 1 cycle:
  - hi/lo are written at the edge entering DONE.
  - done=1 and busy=1 during DONE; next state is IDLE.
- Latency: start accepted in cycle 0 → done high in cycle WIDTH+3 (cycle 35 for WIDTH=32). busy is high in cycles 1..WIDTH+3.
- start while busy: ignored. It does not queue and does not alter operands or op.
- hi/lo hold their values between operations. They change only at DONE, MTHI/MTLO, or reset.
- Signed division:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1 gives lo=MIN, hi=0. There is no trap.
- Division by zero:
  - Full latency is still taken.
  - Result: lo = all ones, hi = a (dividend unmodified, sign included), div_zero=1.
  - div_zero is held until the next accepted start.
- Multiply results are exact 2*WIDTH-bit products: signed for MULT, unsigned for MULTU.

Optional Feature:
- Macro: ALU_MULDIV_MADD_EN.
- When defined:
  - op 6 (MADD) computes {hi,lo} <= {hi,lo} + signed a*b; op 7 (MADDU) uses the unsigned product.
  - The add is performed in FIX using the hi/lo values present at start.
  - Latency is identical to MULT.
  - MTHI/MTLO are rejected while busy, so hi/lo cannot change mid-operation.
- When undefined: op 6/7 are illegal; start is ignored, busy stays 0, and hi/lo are unchanged.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF (WIDTH=32) → busy cycles 1–35, done pulse in cycle 35, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB; then MTLO a=0x1234 → lo=0x1234 next cycle, busy stays 0, hi unchanged.
- DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0, div_zero=0.
- DIVU a=7 b=0 → lo=0xFFFFFFFF hi=7 div_zero=1; subsequent MULTU 2*3 → div_zero clears at start, hi=0 lo=6.
- MULTU 5*5 started; start with DIVU pulsed in cycle 4 → ignored, result hi=0 lo=25. Next op: rst_n low in cycle 10 → busy=0, hi=lo=0 immediately; done never pulses.
- With ALU_MULDIV_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, MADDU a=1 b=1 → hi=1 lo=0. Without the macro the same op=7 start → busy stays 0, hi/lo unchanged.
